slew_ctl: RTL and testbench

Drive side of the slew-limiter interface. Accepts setpoint requests over a valid/ready handshake and presents them on set_out. Generates the rate-limited tick stream and interprets the limiter's motion flag. Issues a one-cycle done pulse when the limiter output has settled at the new setpoint, which lets sequencers (e.g. phase/amplitude ramps) chain moves without software polling.

---
 rtl/slew_ctl.sv | 181 ++++++++++++++++++
 tb/tb_slew_ctl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/slew_ctl.sv
// Drive side of the slew-limiter interface: setpoint handshake, rate-limited tick
// generation and settle detection. Define SLEW_CTL_TIMEOUT_EN to add the RAMP tick-count timeout on err.

// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | ready for a request; set_out holds the last setpoint
// S_SETTLE | new set_out presented, waiting SETTLE clocks before trusting motion
// S_RAMP   | limiter still slewing; divider paces ticks, settle counter guards exit
// S_DONE   | one-cycle done pulse, then back to idle

module slew_ctl #(
    parameter int dw     = 16,
    parameter int pw     = 16,
    parameter int SETTLE = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_val,
    input  logic [dw-1:0] req_data,
    output logic          req_rdy,
    input  logic [pw-1:0] period,
    input  logic          abort,
    input  logic          motion,
    output logic [dw-1:0] set_out,
    output logic          tick,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int sw = ($clog2(SETTLE + 1) < 2) ? 2 : $clog2(SETTLE + 1);
    localparam logic [sw-1:0] settle_ld  = sw'(SETTLE);
    localparam logic [pw-1:0] period_min = pw'(2);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_RAMP   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [sw-1:0] settle_cnt;
    logic [pw-1:0] div;
    logic [pw-1:0] period_eff;
    logic          accept;
    logic          settle_zero;
    logic          div_zero;
    logic          step;
    logic          timeout;

    assign period_eff  = (period < period_min) ? period_min : period;
    assign accept      = (state == S_IDLE) && req_val;
    assign settle_zero = (settle_cnt == '0);
    assign div_zero    = (div == '0);

    // A terminal count with the limiter already at target issues no step, so a
    // divider shorter than the settle window cannot keep re-arming the guard.
    assign step = (state == S_RAMP) && !abort && !timeout && div_zero && motion;

`ifdef SLEW_CTL_TIMEOUT_EN
    localparam logic [dw:0] tick_lim = {1'b1, {dw{1'b0}}};

    logic [dw:0] tick_cnt;
    logic        err_q;

    assign timeout = (state == S_RAMP) && !abort && (tick_cnt > tick_lim);
    assign err     = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
            err_q    <= 1'b0;
        end else if (accept) begin
            tick_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (step) begin
                tick_cnt <= tick_cnt + (dw + 1)'(1);
            end
            if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (settle_zero) begin
                    state_nxt = motion ? S_RAMP : S_DONE;
                end
            end
            S_RAMP: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (timeout) begin
                    state_nxt = S_DONE;
                end else if (settle_zero && !motion) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        req_rdy = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state)
            S_IDLE:   req_rdy = !rst;
            S_SETTLE: busy    = 1'b1;
            S_RAMP:   busy    = 1'b1;
            S_DONE:   done    = 1'b1;
            default: begin
                req_rdy = 1'b0;
            end
        endcase
    end

    // Settle counter, divider, setpoint and the registered step strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            set_out    <= '0;
            tick       <= 1'b0;
            settle_cnt <= '0;
            div        <= '0;
        end else begin
            tick <= step;
            if (accept) begin
                set_out    <= req_data;
                settle_cnt <= settle_ld;
            end else if (state == S_SETTLE) begin
                if (!settle_zero) begin
                    settle_cnt <= settle_cnt - sw'(1);
                end else begin
                    div <= period_eff;
                end
            end else if (state == S_RAMP) begin
                if (step) begin
                    settle_cnt <= settle_ld;
                end else if (!settle_zero) begin
                    settle_cnt <= settle_cnt - sw'(1);
                end
                if (div_zero) begin
                    div <= period_eff;
                end else begin
                    div <= div - pw'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_slew_ctl.sv
// Bench for slew_ctl: a simple limiter model closes the motion loop, while expected
// tick/done/busy timing per move comes from closed-form schedule arithmetic.

module tb_slew_ctl;

    localparam int DW = 8;
    localparam int PW = 8;
    localparam int ST = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_val;
    logic [DW-1:0] req_data;
    logic          req_rdy;
    logic [PW-1:0] period;
    logic          abort;
    logic          motion;
    logic [DW-1:0] set_out;
    logic          tick;
    logic          busy;
    logic          done;
    logic          err;

    logic [DW-1:0] lim;
    logic          hold_motion;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int cur   = 0;

    slew_ctl #(.dw(DW), .pw(PW), .SETTLE(ST)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_val  (req_val),
        .req_data (req_data),
        .req_rdy  (req_rdy),
        .period   (period),
        .abort    (abort),
        .motion   (motion),
        .set_out  (set_out),
        .tick     (tick),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Limiter: one unit step toward set_out per tick.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            lim <= '0;
        end else if (tick && lim != set_out) begin
            lim <= (set_out > lim) ? lim + 1'b1 : lim - 1'b1;
        end
    end

    assign motion = hold_motion | (lim != set_out);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic wait_ready();
        int w;
        w = 0;
        while (req_rdy !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("rdy_before_req", req_rdy, 1'b1);
    endtask

    // abort_at: -1 none, 0 abort during settle, k>0 abort right after the k-th tick.
    task automatic do_move(input int tgt, input int per, input int abort_at);
        int  c, n, pe, t1, done_c, abort_c, stop_c, end_c, ti;
        logic exp_tick;
        wait_ready();
        req_data = DW'(tgt);
        period   = PW'(per);
        req_val  = 1'b1;
        c        = cyc;
        n        = (tgt > cur) ? tgt - cur : cur - tgt;
        pe       = (per < 2) ? 2 : per;
        t1       = c + ST + 3 + pe;
        done_c   = (n == 0) ? c + ST + 2 : t1 + (n - 1) * (pe + 1) + ST + 1;
        abort_c  = -1;
        if (abort_at == 0) begin
            abort_c = c + 2;
        end else if (abort_at > 0 && abort_at < n) begin
            abort_c = t1 + (abort_at - 1) * (pe + 1);
        end
        stop_c = (abort_c >= 0) ? abort_c + 1 : done_c;
        end_c  = (abort_c >= 0) ? abort_c + 3 : done_c + 1;
        while (cyc < end_c) begin
            @(negedge clk);
            req_val = 1'b0;
            abort   = 1'b0;
            ti = cyc - t1;
            exp_tick = (n > 0) && (ti >= 0) && (ti % (pe + 1) == 0) && (ti / (pe + 1) < n)
                       && (abort_c < 0 || cyc <= abort_c);
            check("tick", tick, exp_tick);
            check("done", done, (abort_c < 0) && (cyc == done_c));
            check("busy", busy, cyc < stop_c);
            check("req_rdy", req_rdy, (cyc >= stop_c) && !(abort_c < 0 && cyc == done_c));
            check("set_out", set_out, DW'(tgt));
            check("err", err, 1'b0);
            if (cyc == abort_c) abort = 1'b1;
        end
        if (abort_c < 0) begin
            cur = tgt;
        end else if (abort_at > 0) begin
            cur = (tgt > cur) ? cur + abort_at : cur - abort_at;
        end
        check("lim_pos", lim, DW'(cur));
    endtask

    task automatic idle_abort();
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("idle_abort_busy", busy, 1'b0);
        check("idle_abort_rdy", req_rdy, 1'b1);
        check("idle_abort_tick", tick, 1'b0);
        @(negedge clk);
        check("idle_abort_done", done, 1'b0);
    endtask

    task automatic reset_mid_ramp();
        wait_ready();
        req_data = DW'(cur + 20);
        period   = PW'(5);
        req_val  = 1'b1;
        @(negedge clk);
        req_val = 1'b0;
        repeat (25) @(negedge clk);
        check("busy_before_rst", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("rst_set_out", set_out, 0);
        check("rst_tick", tick, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rdy", req_rdy, 1'b0);
        repeat (2) @(negedge clk);
        check("rst_done_held", done, 1'b0);
        rst = 1'b0;
        cur = 0;
        @(negedge clk);
        check("post_rst_rdy", req_rdy, 1'b1);
        check("post_rst_lim", lim, 0);
    endtask

`ifdef SLEW_CTL_TIMEOUT_EN
    task automatic timeout_test();
        int nt, w;
        wait_ready();
        hold_motion = 1'b1;
        req_data    = DW'(cur);
        period      = '0;
        req_val     = 1'b1;
        @(negedge clk);
        req_val = 1'b0;
        nt = 0;
        w  = 0;
        while (done !== 1'b1 && w < 5000) begin
            if (tick === 1'b1) nt++;
            @(negedge clk);
            w++;
        end
        check("timeout_done", done, 1'b1);
        check("timeout_ticks", nt, (1 << DW) + 1);
        check("timeout_err", err, 1'b1);
        hold_motion = 1'b0;
        @(negedge clk);
        check("timeout_err_sticky", err, 1'b1);
        do_move(cur, 2, -1);
    endtask
`endif

    initial begin
        rst         = 1'b1;
        req_val     = 1'b0;
        req_data    = '0;
        period      = PW'(4);
        abort       = 1'b0;
        hold_motion = 1'b0;
        #1;
        check("reset_rdy", req_rdy, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_tick", tick, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_set_out", set_out, 0);
        check("reset_err", err, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        do_move(8, 4, -1);
        do_move(16, 3, -1);
        do_move(16, 2, -1);
        do_move(21, 0, -1);
        do_move(31, 2, 3);
        idle_abort();
        do_move(20, 1, 0);
        reset_mid_ramp();

        for (int i = 0; i < 30; i++) begin
            int tgt, per, ab, n;
            tgt = cur + int'($urandom_range(24)) - 12;
            if (tgt < 0) tgt = 0;
            if (tgt > 255) tgt = 255;
            per = int'($urandom_range(6));
            n   = (tgt > cur) ? tgt - cur : cur - tgt;
            ab  = -1;
            if ($urandom_range(4) == 0) begin
                ab = (n > 1) ? int'($urandom_range(n - 1)) : 0;
            end
            do_move(tgt, per, ab);
            if ($urandom_range(3) == 0) idle_abort();
        end

`ifdef SLEW_CTL_TIMEOUT_EN
        timeout_test();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
